// File: rtl/norm_shift.sv
`default_nettype none
// ============================================================================
//  Module   : norm_shift
//  Purpose  : Iterative 32-bit normalizer. Accepts an operand on a start
//             pulse and shifts it left one bit per clock until it is
//             normalized, reporting the applied shift count. Logical mode
//             removes leading zeros; signed mode removes redundant sign bits.
//             The count is capped at 31, so a zero operand ends with sa = 31.
//  Ports    : clk    - system clock, rising-edge active
//             clrn   - asynchronous active-low reset
//             start  - request pulse, honoured only in IDLE or DONE
//             d      - 32-bit operand, captured on the accepting edge
//             arith  - 0 = logical normalize, 1 = signed normalize
//             busy   - high while shifting
//             done   - one-cycle result-valid pulse
//             q      - normalized value (d << sa)
//             sa     - left-shift count applied to d
//             zero   - captured operand was zero
//  Revision : 1.0  initial release
// ============================================================================
module norm_shift (
   input  logic        clk,
   input  logic        clrn,
   input  logic        start,
   input  logic [31:0] d,
   input  logic        arith,
   output logic        busy,
   output logic        done,
   output logic [31:0] q,
   output logic [4:0]  sa,
   output logic        zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] q_nx;
   logic [4:0]  sa_nx;
   logic        zero_nx;
   logic        mode;      // latched arith for the operation in flight
   logic        mode_nx;
   logic        norm_ok;

   // Signed mode is normalized once the top two bits differ; logical mode
   // once the top bit is set.
   assign norm_ok = mode ? (q[31] ^ q[30]) : q[31];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= IDLE;
         q     <= 32'd0;
         sa    <= 5'd0;
         zero  <= 1'b0;
         mode  <= 1'b0;
      end else begin
         state <= state_nx;
         q     <= q_nx;
         sa    <= sa_nx;
         zero  <= zero_nx;
         mode  <= mode_nx;
      end
   end

   always_comb begin
      state_nx = state;
      q_nx     = q;
      sa_nx    = sa;
      zero_nx  = zero;
      mode_nx  = mode;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = SHIFT;
               q_nx     = d;
               sa_nx    = 5'd0;
               zero_nx  = (d == 32'd0);
               mode_nx  = arith;
            end else begin
               state_nx = IDLE;
            end
         end
         SHIFT: begin
            // The sa == 31 cap guarantees termination for a zero operand
            // and for an all-ones operand in signed mode.
            if (norm_ok || (sa == 5'd31)) begin
               state_nx = DONE;
            end else begin
               q_nx  = {q[30:0], 1'b0};
               sa_nx = sa + 5'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_norm_shift.sv
`default_nettype none
// ============================================================================
//  Module   : tb_norm_shift
//  Purpose  : Self-checking bench for norm_shift. Each scenario task drives
//             a request, pushes the expected result onto a scoreboard queue,
//             waits (bounded) for done, pops the entry and compares.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_norm_shift;

   logic        clk;
   logic        clrn;
   logic        start;
   logic [31:0] d;
   logic        arith;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [4:0]  sa;
   logic        zero;

   typedef struct packed {
      logic [31:0] q;
      logic [4:0]  sa;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   norm_shift dut (
      .clk   (clk),
      .clrn  (clrn),
      .start (start),
      .d     (d),
      .arith (arith),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .sa    (sa),
      .zero  (zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: count leading zeros (logical) or redundant sign bits (signed),
   // capped at 31.
   function automatic void model(input logic [31:0] dv, input bit a,
                                 output logic [31:0] eq, output logic [4:0] esa);
      int n;
      n = 0;
      if (a) begin
         for (int i = 30; i >= 0; i--) begin
            if (dv[i] == dv[31]) n++;
            else break;
         end
      end else begin
         for (int i = 31; i >= 0; i--) begin
            if (dv[i] == 1'b0) n++;
            else break;
         end
      end
      if (n > 31) n = 31;
      esa = n[4:0];
      eq  = dv << n;
   endfunction

   // Drive a request in the current (low) clock phase; sampled next posedge.
   task automatic drive_start(input logic [31:0] dv, input logic a);
      start = 1'b1;
      d     = dv;
      arith = a;
   endtask

   task automatic issue(input logic [31:0] dv, input logic a);
      @(negedge clk);
      drive_start(dv, a);
   endtask

   // Waits up to 40 cycles for done; cyc is the cycle number where done was
   // seen (accepting cycle = 0), bc counts busy cycles before it.
   task automatic wait_done(output int cyc, output int bc, output bit seen);
      cyc  = 0;
      bc   = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (done) seen = 1'b1;
         else if (busy) bc++;
      end
   endtask

   task automatic test_reset();
      clrn = 1'b1;
      #2 clrn = 1'b0;
      #1;
      total++;
      if ({busy, done, q, sa, zero} !== 40'd0)
         $display("FAIL reset_outputs: got busy=%b done=%b q=%h sa=%0d zero=%b expected all 0",
                  busy, done, q, sa, zero);
      else passed++;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00)
         $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
      else passed++;
      clrn = 1'b1;
   endtask

   task automatic test_logical();
      int cyc, bc; bit seen; exp_t e;
      issue(32'h0001_0000, 1'b0);
      sb.push_back(exp_t'{32'h8000_0000, 5'd15, 1'b0});
      wait_done(cyc, bc, seen);
      total++;
      if (!seen || cyc != 17)
         $display("FAIL logical_latency: got cycle %0d (seen=%0d) expected 17", cyc, seen);
      else passed++;
      total++;
      if (bc != 16)
         $display("FAIL logical_busy: got %0d busy cycles expected 16", bc);
      else passed++;
      e = sb.pop_front();
      total++;
      if ({q, sa, zero} !== e)
         $display("FAIL logical_result: got q=%h sa=%0d zero=%b expected q=%h sa=%0d zero=%b",
                  q, sa, zero, e.q, e.sa, e.zero);
      else passed++;
   endtask

   task automatic test_signed();
      int cyc, bc; bit seen; exp_t e;
      issue(32'hFFFF_FF00, 1'b1);
      sb.push_back(exp_t'{32'h8000_0000, 5'd23, 1'b0});
      wait_done(cyc, bc, seen);
      total++;
      if (!seen || cyc != 25)
         $display("FAIL signed_neg_latency: got cycle %0d (seen=%0d) expected 25", cyc, seen);
      else passed++;
      e = sb.pop_front();
      total++;
      if ({q, sa, zero} !== e)
         $display("FAIL signed_neg_result: got q=%h sa=%0d zero=%b expected q=%h sa=%0d zero=%b",
                  q, sa, zero, e.q, e.sa, e.zero);
      else passed++;

      issue(32'h0000_0001, 1'b1);
      sb.push_back(exp_t'{32'h4000_0000, 5'd30, 1'b0});
      wait_done(cyc, bc, seen);
      e = sb.pop_front();
      total++;
      if (!seen || {q, sa, zero} !== e)
         $display("FAIL signed_pos_result: got q=%h sa=%0d zero=%b seen=%0d expected q=%h sa=%0d zero=%b",
                  q, sa, zero, seen, e.q, e.sa, e.zero);
      else passed++;

      issue(32'hFFFF_FFFF, 1'b1);
      sb.push_back(exp_t'{32'h8000_0000, 5'd31, 1'b0});
      wait_done(cyc, bc, seen);
      e = sb.pop_front();
      total++;
      if (!seen || cyc != 33 || {q, sa, zero} !== e)
         $display("FAIL signed_ones: got q=%h sa=%0d zero=%b cycle=%0d expected q=%h sa=%0d zero=%b cycle=33",
                  q, sa, zero, cyc, e.q, e.sa, e.zero);
      else passed++;
   endtask

   task automatic test_zero();
      int cyc, bc; bit seen; exp_t e;
      issue(32'h0, 1'b0);
      sb.push_back(exp_t'{32'h0, 5'd31, 1'b1});
      wait_done(cyc, bc, seen);
      total++;
      if (!seen || cyc != 33)
         $display("FAIL zero_latency: got cycle %0d (seen=%0d) expected 33", cyc, seen);
      else passed++;
      e = sb.pop_front();
      total++;
      if ({q, sa, zero} !== e)
         $display("FAIL zero_result: got q=%h sa=%0d zero=%b expected q=%h sa=%0d zero=%b",
                  q, sa, zero, e.q, e.sa, e.zero);
      else passed++;
      // Result must hold, with done low, until the next accepted start.
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, q, sa, zero} !== {2'b00, e})
         $display("FAIL zero_hold: got busy=%b done=%b q=%h sa=%0d zero=%b expected 0 0 %h %0d %b",
                  busy, done, q, sa, zero, e.q, e.sa, e.zero);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int cyc, bc; bit seen; exp_t e;
      issue(32'h4000_0000, 1'b0);
      sb.push_back(exp_t'{32'h8000_0000, 5'd1, 1'b0});
      @(negedge clk);              // cycle 1: in SHIFT, re-pulse start
      drive_start(32'h0000_0001, 1'b0);
      wait_done(cyc, bc, seen);
      total++;
      if (!seen || cyc + 1 != 3)
         $display("FAIL b2b_first_latency: got cycle %0d (seen=%0d) expected 3", cyc + 1, seen);
      else passed++;
      e = sb.pop_front();
      total++;
      if ({q, sa, zero} !== e)
         $display("FAIL b2b_first_result: got q=%h sa=%0d zero=%b expected q=%h sa=%0d zero=%b",
                  q, sa, zero, e.q, e.sa, e.zero);
      else passed++;
      // Start in the DONE cycle: accepted immediately.
      drive_start(32'h0000_0001, 1'b0);
      sb.push_back(exp_t'{32'h8000_0000, 5'd31, 1'b0});
      wait_done(cyc, bc, seen);
      total++;
      if (!seen || cyc != 33)
         $display("FAIL b2b_second_latency: got cycle %0d (seen=%0d) expected 33", cyc, seen);
      else passed++;
      e = sb.pop_front();
      total++;
      if ({q, sa, zero} !== e)
         $display("FAIL b2b_second_result: got q=%h sa=%0d zero=%b expected q=%h sa=%0d zero=%b",
                  q, sa, zero, e.q, e.sa, e.zero);
      else passed++;
   endtask

   task automatic test_reset_midop();
      int cyc, bc, dcnt; bit seen; exp_t e;
      issue(32'h0000_0001, 1'b0);
      sb.push_back(exp_t'{32'h8000_0000, 5'd31, 1'b0});
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 clrn = 1'b0;
      #1;
      total++;
      if ({busy, done, q, sa, zero} !== 40'd0)
         $display("FAIL midop_reset_outputs: got busy=%b done=%b q=%h sa=%0d zero=%b expected all 0",
                  busy, done, q, sa, zero);
      else passed++;
      sb.delete();                 // operation abandoned
      @(negedge clk);
      clrn = 1'b1;
      dcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      total++;
      if (dcnt != 0)
         $display("FAIL midop_no_done: got %0d done cycles expected 0", dcnt);
      else passed++;
      issue(32'h8000_0000, 1'b0);
      sb.push_back(exp_t'{32'h8000_0000, 5'd0, 1'b0});
      wait_done(cyc, bc, seen);
      total++;
      if (!seen || cyc != 2)
         $display("FAIL midop_restart_latency: got cycle %0d (seen=%0d) expected 2", cyc, seen);
      else passed++;
      e = sb.pop_front();
      total++;
      if ({q, sa, zero} !== e)
         $display("FAIL midop_restart_result: got q=%h sa=%0d zero=%b expected q=%h sa=%0d zero=%b",
                  q, sa, zero, e.q, e.sa, e.zero);
      else passed++;
   endtask

   task automatic test_random();
      int cyc, bc, r; bit seen; exp_t e;
      logic [31:0] dv, eq, back;
      logic [4:0]  esa;
      logic        a;
      for (int i = 0; i < 1000; i++) begin
         dv = $urandom;
         r  = $urandom_range(0, 7);
         // Bias some operands toward small magnitudes for long shifts.
         if (r[1:0] == 2'd0) dv = dv >> r;
         if (r[2]) dv = dv >> 16;
         if (dv == 32'd0) dv = 32'd1;
         r = $urandom_range(0, 1);
         a = r[0];
         model(dv, a, eq, esa);
         issue(dv, a);
         sb.push_back(exp_t'{eq, esa, 1'b0});
         wait_done(cyc, bc, seen);
         e = sb.pop_front();
         total++;
         if (!seen || cyc != int'(e.sa) + 2 || {q, sa, zero} !== e)
            $display("FAIL rand_result: d=%h arith=%b got q=%h sa=%0d zero=%b cycle=%0d expected q=%h sa=%0d cycle=%0d",
                     dv, a, q, sa, zero, cyc, e.q, e.sa, int'(e.sa) + 2);
         else passed++;
         if (a) back = $signed(q) >>> sa;
         else   back = q >> sa;
         total++;
         if (back !== dv || (a ? (q[31] == q[30]) : !q[31]))
            $display("FAIL rand_inverse: d=%h arith=%b got q=%h sa=%0d restored=%h expected restored=%h normalized",
                     dv, a, q, sa, back, dv);
         else passed++;
      end
   endtask

   initial begin
      clrn  = 1'b1;
      start = 1'b0;
      d     = 32'd0;
      arith = 1'b0;
      test_reset();
      test_logical();
      test_signed();
      test_zero();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/norm_shift.md
NORM_SHIFT -- requirements
Module: norm_shift

Interface
REQ-001 Parameters: none; datapath SHALL be fixed at 32 bits, count at 5 bits.
REQ-002 clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-003 clrn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 d  input  32  operand; captured on the edge that accepts start.
REQ-006 arith  input  1  0 = logical normalize (leading zeros), 1 = signed normalize (redundant sign bits); captured with d.
REQ-007 busy  output  1  high only while in SHIFT.
REQ-008 done  output  1  one-cycle result-valid pulse.
REQ-009 q  output  32  normalized value.
REQ-010 sa  output  5  left-shift count applied to d to produce q.
REQ-011 zero  output  1  high when the captured d == 0.

Function
REQ-012 The block SHALL be the inverse of the datapath shifter: it SHALL find sa such that q = d << sa is normalized, so a right shift of q by sa (logical or arithmetic, per arith) restores d whenever zero == 0.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE, registered, with IDLE as the reset state.
REQ-014 IDLE or DONE with start == 1: on the edge, load q <= d, sa <= 0, zero <= (d == 0), latch arith, and go to SHIFT.
REQ-015 IDLE with start == 0 SHALL stay in IDLE; DONE with start == 0 SHALL go to IDLE.
REQ-016 SHIFT normalization test: logical mode requires q[31] == 1; arith mode requires q[31] != q[30].
REQ-017 SHIFT, test true or sa == 31: the next state SHALL be DONE, with q and sa unchanged.
REQ-018 SHIFT otherwise: q <= q << 1 (zero fill), sa <= sa + 1, and the state stays SHIFT.
REQ-019 Latency: for the cycle in which start is sampled as cycle 0, done SHALL be high in exactly cycle sa+2 (maximum cycle 33).
REQ-020 done SHALL be high exactly while the state is DONE, for one cycle per accepted start.
REQ-021 start while in SHIFT SHALL be ignored, with no restart and no queuing.
REQ-022 start during the DONE cycle SHALL be accepted (back-to-back operation); done still pulses for that cycle.
REQ-023 Input d == 0 SHALL terminate by the sa == 31 cap with q = 0, sa = 31, zero = 1.
REQ-024 Arith input 0xFFFFFFFF SHALL terminate at sa == 31 with q = 0x80000000 and zero = 0.
REQ-025 q, sa and zero SHALL hold their values after done until the next accepted start; d and arith SHALL be don't-care outside the accepting edge.

Reset
REQ-026 clrn low SHALL immediately, without waiting for a clock, force state to IDLE and busy, done, q, sa and zero to 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-028 After clrn deasserts, the first start sampled SHALL be accepted normally.

Verification
REQ-029 Logical normalize: start with d = 0x00010000, arith = 0 -> done in cycle 17, q = 0x80000000, sa = 15, zero = 0; busy high in cycles 1-16.
REQ-030 Signed normalize: d = 0xFFFFFF00, arith = 1 -> sa = 23, q = 0x80000000, done in cycle 25; a second case d = 0x00000001, arith = 1 -> sa = 30, q = 0x40000000.
REQ-031 Zero operand: d = 0, arith = 0 -> done in cycle 33, q = 0, sa = 31, zero = 1.
REQ-032 Handshake: start with d = 0x40000000 (logical), start re-pulsed with d = 1 during SHIFT -> ignored; start with d = 0x00000001 in the DONE cycle -> accepted, and the second done gives sa = 31, q = 0x80000000.
REQ-033 Reset mid-op: d = 0x00000001 logical, clrn pulsed low in cycle 10 -> all outputs 0 asynchronously, no done; the next start with d = 0x80000000 gives sa = 0, done in cycle 2.
REQ-034 Randomized inverse check: over 1000 random d and arith values with d != 0, q >> sa (arithmetic when arith = 1) SHALL equal d, and the REQ-016 test SHALL hold on q.
